// File: rtl/axi4_slave_ram.sv
// AXI4-style INCR burst responder backed by a synchronous beat-addressed RAM.
// Independent read and write FSMs; no backpressure on R, slave-paced W beats.
module axi4_slave_ram #(
   parameter int memWidth      = 256,
   parameter int addressLength = 28,
   parameter int depthLog2     = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [3:0]               S_ARID,
   input  logic [addressLength-1:0] S_ARADDR,
   input  logic                     S_ARVALID,
   output logic                     S_ARREADY,
   input  logic [3:0]               S_ARLEN,
   output logic [3:0]               S_RID,
   output logic [memWidth-1:0]      S_RDATA,
   output logic                     S_RVALID,
   output logic                     S_RLAST,
   input  logic [3:0]               S_AWID,
   input  logic [addressLength-1:0] S_AWADDR,
   input  logic                     S_AWVALID,
   output logic                     S_AWREADY,
   input  logic [3:0]               S_AWLEN,
   input  logic [memWidth-1:0]      S_WDATA,
   output logic                     S_WREADY,
   output logic                     S_WLAST
);
   localparam int DEPTH = 1 << depthLog2;

   typedef enum logic {R_IDLE, R_BURST} r_state_t;
   typedef enum logic {W_IDLE, W_BURST} w_state_t;

   logic [memWidth-1:0]  mem [DEPTH];
   logic                 armed;

   r_state_t             r_state, r_next;
   logic [depthLog2-1:0] r_idx, rd_idx;
   logic [3:0]           r_cnt, r_len, r_id;
   logic [memWidth-1:0]  rdata_q;
   logic                 ar_go, r_end;

   w_state_t             w_state, w_next;
   logic [depthLog2-1:0] w_idx;
   logic [3:0]           w_cnt, w_len;
   logic                 aw_go, w_end;

   // Upper address bits and the write ID are intentionally ignored.
   logic unused_ok;
   assign unused_ok = ^{S_AWID, S_ARADDR[addressLength-1:depthLog2],
                        S_AWADDR[addressLength-1:depthLog2]};

   // Readies stay low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) armed <= 1'b0;
      else        armed <= 1'b1;
   end

   assign ar_go = S_ARREADY && S_ARVALID;
   assign r_end = (r_state == R_BURST) && (r_cnt == r_len);
   assign aw_go = S_AWREADY && S_AWVALID;
   assign w_end = (w_state == W_BURST) && (w_cnt == w_len);

   // ---------------- read FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= R_IDLE;
      else        r_state <= r_next;
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_go) r_next = R_BURST;
         R_BURST: if (r_end) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      S_ARREADY = armed && (r_state == R_IDLE);
      S_RVALID  = (r_state == R_BURST);
      S_RLAST   = r_end;
      S_RDATA   = S_RVALID ? rdata_q : '0;
      S_RID     = S_RVALID ? r_id : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
         r_cnt <= '0;
         r_len <= '0;
         r_id  <= '0;
      end else if (ar_go) begin
         r_idx <= S_ARADDR[depthLog2-1:0] + 1'b1;
         r_cnt <= '0;
         r_len <= S_ARLEN;
         r_id  <= S_ARID;
      end else if (r_state == R_BURST) begin
         r_idx <= r_idx + 1'b1;
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // r_idx always points at the beat after the one presented on S_RDATA.
   assign rd_idx = (r_state == R_IDLE) ? S_ARADDR[depthLog2-1:0] : r_idx;

   always_ff @(posedge clk) begin
      rdata_q <= mem[rd_idx];
   end

   // ---------------- write FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) w_state <= W_IDLE;
      else        w_state <= w_next;
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (aw_go) w_next = W_BURST;
         W_BURST: if (w_end) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      S_AWREADY = armed && (w_state == W_IDLE);
      S_WREADY  = (w_state == W_BURST);
      S_WLAST   = w_end;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_idx <= '0;
         w_cnt <= '0;
         w_len <= '0;
      end else if (aw_go) begin
         w_idx <= S_AWADDR[depthLog2-1:0];
         w_cnt <= '0;
         w_len <= S_AWLEN;
      end else if (w_state == W_BURST) begin
         w_idx <= w_idx + 1'b1;
         w_cnt <= w_cnt + 1'b1;
      end
   end

   // Same-edge read of this index sees the old word (both are NBA updates).
   always_ff @(posedge clk) begin
      if (S_WREADY) mem[w_idx] <= S_WDATA;
   end

endmodule

// File: tb/tb_axi4_slave_ram.sv
// Scoreboard bench for axi4_slave_ram: a reference memory predicts each read
// beat when the AR is issued; a negedge monitor pops and compares R beats.
module tb_axi4_slave_ram;
   localparam int MW = 256;
   localparam int AL = 28;
   localparam int DL = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    S_ARID, S_ARLEN, S_RID, S_AWID, S_AWLEN;
   logic [AL-1:0] S_ARADDR, S_AWADDR;
   logic          S_ARVALID, S_ARREADY, S_RVALID, S_RLAST;
   logic          S_AWVALID, S_AWREADY, S_WREADY, S_WLAST;
   logic [MW-1:0] S_RDATA, S_WDATA;

   axi4_slave_ram #(.memWidth(MW), .addressLength(AL), .depthLog2(DL)) dut (
      .clk(clk), .rst_n(rst_n),
      .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
      .S_ARLEN(S_ARLEN), .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RVALID(S_RVALID),
      .S_RLAST(S_RLAST), .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID),
      .S_AWREADY(S_AWREADY), .S_AWLEN(S_AWLEN), .S_WDATA(S_WDATA), .S_WREADY(S_WREADY),
      .S_WLAST(S_WLAST)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [MW-1:0] data;
      logic [3:0]    id;
      logic          last;
   } rexp_t;

   rexp_t         rq[$];
   rexp_t         mon_e;
   logic [MW-1:0] ref_mem [1<<DL];
   int            n_tests = 0;
   int            n_fail = 0;
   int            acc[$];

   task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (S_RVALID) begin
            if (rq.size() == 0) chk("r_unexpected_beat", MW'(1), MW'(0));
            else begin
               mon_e = rq.pop_front();
               chk("rdata", S_RDATA, mon_e.data);
               chk("rid", MW'(S_RID), MW'(mon_e.id));
               chk("rlast", MW'(S_RLAST), MW'(mon_e.last));
            end
         end else begin
            chk("r_idle_data", S_RDATA | MW'(S_RID), MW'(0));
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_arready"}, MW'(S_ARREADY), MW'(0));
      chk({tag, "_awready"}, MW'(S_AWREADY), MW'(0));
      chk({tag, "_rvalid"},  MW'(S_RVALID),  MW'(0));
      chk({tag, "_rlast"},   MW'(S_RLAST),   MW'(0));
      chk({tag, "_wready"},  MW'(S_WREADY),  MW'(0));
      chk({tag, "_wlast"},   MW'(S_WLAST),   MW'(0));
      chk({tag, "_rdata"},   S_RDATA,        MW'(0));
      chk({tag, "_rid"},     MW'(S_RID),     MW'(0));
   endtask

   task automatic wait_ar();
      int n = 0;
      while (!S_ARREADY && n < 50) begin @(negedge clk); n++; end
      chk("arready_timeout", MW'(S_ARREADY), MW'(1));
   endtask

   task automatic wait_aw();
      int n = 0;
      while (!S_AWREADY && n < 50) begin @(negedge clk); n++; end
      chk("awready_timeout", MW'(S_AWREADY), MW'(1));
   endtask

   task automatic drain();
      int n = 0;
      while (rq.size() != 0 && n < 60) begin @(negedge clk); n++; end
      chk("r_drain", MW'(rq.size()), MW'(0));
   endtask

   task automatic push_beats(input logic [AL-1:0] addr, input logic [3:0] len, input logic [3:0] id);
      rexp_t e;
      logic [DL-1:0] idx;
      for (int b = 0; b <= int'(len); b++) begin
         idx    = addr[DL-1:0] + DL'(b);
         e.data = ref_mem[idx];
         e.id   = id;
         e.last = (b == int'(len));
         rq.push_back(e);
      end
   endtask

   // Called at a negedge; returns at a negedge (or with rst_n low on abort).
   task automatic do_write(input logic [AL-1:0] addr, input logic [3:0] len,
                           input logic [MW-1:0] base, input int abort_beat);
      logic [DL-1:0] idx;
      wait_aw();
      S_AWVALID = 1'b1; S_AWADDR = addr; S_AWLEN = len; S_AWID = 4'h9;
      @(posedge clk); #1 S_AWVALID = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         @(negedge clk);
         if (b == abort_beat) begin
            rst_n = 1'b0;
            #1 chk_zero("mid_rst");
            return;
         end
         chk("wready", MW'(S_WREADY), MW'(1));
         chk("wlast", MW'(S_WLAST), MW'(b == int'(len)));
         if (b == 0) chk("awready_busy", MW'(S_AWREADY), MW'(0));
         S_WDATA = base + MW'(b);
         @(posedge clk);
         idx = addr[DL-1:0] + DL'(b);
         ref_mem[idx] = base + MW'(b);
      end
      @(negedge clk);
      chk("wready_end", MW'(S_WREADY), MW'(0));
      chk("awready_back", MW'(S_AWREADY), MW'(1));
   endtask

   task automatic do_read(input logic [AL-1:0] addr, input logic [3:0] len, input logic [3:0] id);
      wait_ar();
      S_ARVALID = 1'b1; S_ARADDR = addr; S_ARLEN = len; S_ARID = id;
      push_beats(addr, len, id);
      @(posedge clk); #1 S_ARVALID = 1'b0;
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      S_ARID = '0; S_ARADDR = '0; S_ARVALID = 1'b0; S_ARLEN = '0;
      S_AWID = '0; S_AWADDR = '0; S_AWVALID = 1'b0; S_AWLEN = '0; S_WDATA = '0;

      // reset
      repeat (3) @(negedge clk);
      chk_zero("rst");
      rst_n = 1'b1;
      #1 chk("arready_pre_edge", MW'(S_ARREADY), MW'(0));
      @(negedge clk);
      chk("arready_post_rst", MW'(S_ARREADY), MW'(1));
      chk("awready_post_rst", MW'(S_AWREADY), MW'(1));
      chk("rvalid_post_rst", MW'(S_RVALID), MW'(0));
      chk("wready_post_rst", MW'(S_WREADY), MW'(0));

      // single beat
      do_write(28'h5, 4'd0, MW'('hA5), -1);
      do_read(28'h5, 4'd0, 4'd3);

      // 16-beat burst; readback uses nonzero upper address bits
      do_write(28'h100, 4'd15, MW'(0), -1);
      do_read(28'h4000100, 4'd15, 4'd7);

      // wrap-around at the top of the RAM
      do_write(28'd1022, 4'd3, MW'(1), -1);
      do_read(28'h0, 4'd1, 4'd2);

      // same-index read and write on one edge
      do_write(28'h40, 4'd0, MW'('hAAAA), -1);
      wait_ar();
      S_AWVALID = 1'b1; S_AWADDR = 28'h40; S_AWLEN = 4'd0;
      @(posedge clk); #1 S_AWVALID = 1'b0;
      @(negedge clk);
      chk("conc_wready", MW'(S_WREADY), MW'(1));
      S_WDATA = MW'('hBBBB);
      S_ARVALID = 1'b1; S_ARADDR = 28'h40; S_ARLEN = 4'd0; S_ARID = 4'd5;
      push_beats(28'h40, 4'd0, 4'd5);
      @(posedge clk);
      ref_mem[10'h40] = MW'('hBBBB);
      #1 S_ARVALID = 1'b0;
      drain();
      @(negedge clk);
      do_read(28'h40, 4'd0, 4'd6);

      // ARVALID held high with len 1: accepts every 3 cycles
      do_write(28'h300, 4'd1, MW'('h77), -1);
      wait_ar();
      S_ARVALID = 1'b1; S_ARADDR = 28'h300; S_ARLEN = 4'd1; S_ARID = 4'd4;
      for (int i = 0; i < 9; i++) begin
         if (S_ARREADY) begin
            push_beats(28'h300, 4'd1, 4'd4);
            acc.push_back(i);
         end
         @(negedge clk);
      end
      S_ARVALID = 1'b0;
      drain();
      chk("b2b_accepts", MW'(acc.size()), MW'(3));
      if (acc.size() == 3) begin
         chk("b2b_gap0", MW'(acc[1] - acc[0]), MW'(3));
         chk("b2b_gap1", MW'(acc[2] - acc[1]), MW'(3));
      end
      @(negedge clk);

      // reset during beat 4 of an 8-beat write
      do_write(28'h200, 4'd7, MW'('h1000), -1);
      do_write(28'h200, 4'd7, MW'('h2000), 3);
      repeat (2) @(negedge clk);
      chk_zero("rst_hold");
      rst_n = 1'b1;
      @(negedge clk);
      do_read(28'h200, 4'd7, 4'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
